// File: rtl/letc_core_pkg.sv
// Shared LETC core definitions: CSR index type, CSR op encoding, counter-bank
// index constants and the explicit-access decode helper.
package letc_core_pkg;

  typedef logic [11:0] csr_idx_t;

  typedef enum logic [1:0] {
    CSR_OP_WRITE = 2'd0,
    CSR_OP_SET   = 2'd1,
    CSR_OP_CLEAR = 2'd2
  } csr_op_e;

  localparam csr_idx_t CSR_MCYCLE        = 12'hB00;
  localparam csr_idx_t CSR_MINSTRET      = 12'hB02;
  localparam csr_idx_t CSR_MHPMCOUNTER3  = 12'hB03;
  localparam csr_idx_t CSR_MCYCLEH       = 12'hB80;
  localparam csr_idx_t CSR_MINSTRETH     = 12'hB82;
  localparam csr_idx_t CSR_MHPMCOUNTER3H = 12'hB83;
  localparam csr_idx_t CSR_MCOUNTEREN    = 12'h306;
  localparam csr_idx_t CSR_MCOUNTINHIBIT = 12'h320;
  localparam csr_idx_t CSR_MHPMEVENT3    = 12'h323;
  localparam csr_idx_t CSR_MSCRATCH      = 12'h340;
  localparam csr_idx_t CSR_CYCLE         = 12'hC00;
  localparam csr_idx_t CSR_CYCLEH        = 12'hC80;

  localparam int unsigned HPM_BASE = 3;

  typedef enum logic [2:0] {
    CSR_K_NONE,
    CSR_K_COUNTER,
    CSR_K_EVENT,
    CSR_K_INHIBIT,
    CSR_K_COUNTEREN,
    CSR_K_SCRATCH
  } csr_kind_e;

  typedef struct packed {
    csr_kind_e  kind;
    logic       hi;
    logic [4:0] num;
  } csr_dec_t;

  function automatic logic [31:0] csr_apply_op(csr_op_e op, logic [31:0] old, logic [31:0] wdata);
    logic [31:0] res;
    case (op)
      CSR_OP_WRITE: res = wdata;
      CSR_OP_SET:   res = old | wdata;
      CSR_OP_CLEAR: res = old & ~wdata;
      default:      res = old;
    endcase
    return res;
  endfunction

  // Classify an index; CSR_K_NONE means unimplemented in this bank.
  function automatic csr_dec_t csr_decode(csr_idx_t idx, int unsigned num_hpm);
    csr_dec_t d;
    logic     hpm_ok;
    d.kind = CSR_K_NONE;
    d.hi   = idx[7];
    d.num  = idx[4:0];
    hpm_ok = (32'(idx[4:0]) >= HPM_BASE) && (32'(idx[4:0]) < HPM_BASE + num_hpm);
    if ((idx[11:8] == 4'hB || idx[11:8] == 4'hC) && idx[6:5] == 2'b00) begin
      if (idx[4:0] == 5'd0 || idx[4:0] == 5'd2 || hpm_ok) d.kind = CSR_K_COUNTER;
    end else if (idx[11:5] == 7'b0011001) begin
      if (idx[4:0] == 5'd0)  d.kind = CSR_K_INHIBIT;
      else if (hpm_ok)       d.kind = CSR_K_EVENT;
    end else if (idx == CSR_MCOUNTEREN) begin
      d.kind = CSR_K_COUNTEREN;
    end else if (idx == CSR_MSCRATCH) begin
      d.kind = CSR_K_SCRATCH;
    end
    return d;
  endfunction

endpackage

// File: rtl/letc_core_csr_counters_if.sv
// Explicit CSR read/write port shared by ID/WB and the counter bank.
interface letc_core_csr_counters_if;
  import letc_core_pkg::*;

  logic        csr_explicit_ren;
  csr_idx_t    csr_explicit_ridx;
  logic [31:0] csr_explicit_rdata;
  logic        csr_explicit_rill;
  logic        csr_explicit_wen;
  csr_idx_t    csr_explicit_widx;
  logic [31:0] csr_explicit_wdata;
  csr_op_e     csr_explicit_wop;
  logic        csr_explicit_will;

  modport master (
    output csr_explicit_ren, csr_explicit_ridx,
    output csr_explicit_wen, csr_explicit_widx, csr_explicit_wdata, csr_explicit_wop,
    input  csr_explicit_rdata, csr_explicit_rill, csr_explicit_will
  );

  modport slave (
    input  csr_explicit_ren, csr_explicit_ridx,
    input  csr_explicit_wen, csr_explicit_widx, csr_explicit_wdata, csr_explicit_wop,
    output csr_explicit_rdata, csr_explicit_rill, csr_explicit_will
  );
endinterface

// File: rtl/letc_core_csr_counter64.sv
// One 64-bit wrapping counter; a write to either half replaces that cycle's
// increment and leaves the other half at its pre-increment value.
module letc_core_csr_counter64 #(
  parameter int unsigned INC_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [INC_W-1:0] inc,
  input  logic             inhibit,
  input  logic             wen_lo,
  input  logic             wen_hi,
  input  logic [31:0]      wdata,
  output logic [63:0]      count
);

  always_ff @(posedge clk) begin
    if (!rst_n)        count <= '0;
    else if (wen_lo)   count <= {count[63:32], wdata};
    else if (wen_hi)   count <= {wdata, count[31:0]};
    else if (!inhibit) count <= count + 64'(inc);
  end

endmodule

// File: rtl/letc_core_csr_counters.sv
// Machine counter/CSR bank: mcycle, minstret, hpm counters with event selectors,
// mcountinhibit, mcounteren, mscratch, plus explicit-access legality checks.
module letc_core_csr_counters
  import letc_core_pkg::*;
#(
  parameter int unsigned NUM_HPM    = 4,
  parameter int unsigned NUM_EVENTS = 8,
  parameter int unsigned RETIRE_W   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            priv,
  input  logic [RETIRE_W-1:0]   retire_count,
  input  logic [NUM_EVENTS-1:0] hpm_event,
  letc_core_csr_counters_if.slave csr
);

  localparam int unsigned CNT_N = 2 + NUM_HPM;
  localparam int unsigned EV_N  = (NUM_HPM == 0) ? 1 : NUM_HPM;
  // Bits 0, 2 and 3..2+NUM_HPM exist in mcountinhibit/mcounteren
  localparam logic [31:0] CNT_MASK = 32'((64'd1 << (NUM_HPM + 3)) - 64'd8) | 32'h5;
  localparam logic [1:0]  PRIV_M   = 2'b11;

  logic [63:0] cnt [CNT_N];
  logic [7:0]  mhpmevent [EV_N];
  logic [31:0] mcountinhibit;
  logic [31:0] mcounteren;
  logic [31:0] mscratch;

  csr_dec_t    rdec;
  csr_dec_t    wdec;
  logic        rill_c;
  logic        will_c;
  logic        wcommit;
  logic [31:0] rval;
  logic [31:0] wold;
  logic [31:0] wnew;

  // Counter slot -> CSR counter number (slot 1 is minstret, number 2)
  function automatic logic [4:0] slot_num(int s);
    return (s == 0) ? 5'd0 : (s == 1) ? 5'd2 : 5'(s + 1);
  endfunction

  assign rdec = csr_decode(csr.csr_explicit_ridx, NUM_HPM);
  assign wdec = csr_decode(csr.csr_explicit_widx, NUM_HPM);

  always_comb begin
    rill_c = (rdec.kind == CSR_K_NONE) || (priv < csr.csr_explicit_ridx[9:8]);
    if (rdec.kind == CSR_K_COUNTER && csr.csr_explicit_ridx[11:8] == 4'hC &&
        priv != PRIV_M && !mcounteren[rdec.num])
      rill_c = 1'b1;
    will_c = (wdec.kind == CSR_K_NONE) || (csr.csr_explicit_widx[11:10] == 2'b11) ||
             (priv < csr.csr_explicit_widx[9:8]);
  end

  // Current register values at the read index and at the write index
  always_comb begin
    rval = '0;
    wold = '0;
    for (int s = 0; s < CNT_N; s++) begin
      if (rdec.kind == CSR_K_COUNTER && rdec.num == slot_num(s))
        rval = rdec.hi ? cnt[s][63:32] : cnt[s][31:0];
      if (wdec.kind == CSR_K_COUNTER && wdec.num == slot_num(s))
        wold = wdec.hi ? cnt[s][63:32] : cnt[s][31:0];
    end
    for (int h = 0; h < NUM_HPM; h++) begin
      if (rdec.kind == CSR_K_EVENT && rdec.num == 5'(h + HPM_BASE)) rval = {24'b0, mhpmevent[h]};
      if (wdec.kind == CSR_K_EVENT && wdec.num == 5'(h + HPM_BASE)) wold = {24'b0, mhpmevent[h]};
    end
    case (rdec.kind)
      CSR_K_INHIBIT:   rval = mcountinhibit;
      CSR_K_COUNTEREN: rval = mcounteren;
      CSR_K_SCRATCH:   rval = mscratch;
      default: ;
    endcase
    case (wdec.kind)
      CSR_K_INHIBIT:   wold = mcountinhibit;
      CSR_K_COUNTEREN: wold = mcounteren;
      CSR_K_SCRATCH:   wold = mscratch;
      default: ;
    endcase
  end

  assign csr.csr_explicit_rill  = csr.csr_explicit_ren & rill_c;
  assign csr.csr_explicit_rdata = (csr.csr_explicit_ren && !rill_c) ? rval : '0;
  assign csr.csr_explicit_will  = csr.csr_explicit_wen & will_c;
  assign wcommit                = csr.csr_explicit_wen & ~will_c;
  assign wnew                   = csr_apply_op(csr.csr_explicit_wop, wold, csr.csr_explicit_wdata);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcountinhibit <= '0;
      mcounteren    <= '0;
      mscratch      <= '0;
      for (int h = 0; h < EV_N; h++) mhpmevent[h] <= '0;
    end else if (wcommit) begin
      case (wdec.kind)
        CSR_K_INHIBIT:   mcountinhibit <= wnew & CNT_MASK;
        CSR_K_COUNTEREN: mcounteren    <= wnew & CNT_MASK;
        CSR_K_SCRATCH:   mscratch      <= wnew;
        CSR_K_EVENT: begin
          for (int h = 0; h < NUM_HPM; h++)
            if (wdec.num == 5'(h + HPM_BASE)) mhpmevent[h] <= wnew[7:0];
        end
        default: ;
      endcase
    end
  end

  for (genvar s = 0; s < CNT_N; s++) begin : g_cnt
    localparam int unsigned N = (s == 0) ? 0 : (s == 1) ? 2 : s + 1;
    logic [RETIRE_W-1:0] inc;
    logic                wen_lo;
    logic                wen_hi;

    if (s == 0) begin : g_cycle
      assign inc = RETIRE_W'(1);
    end else if (s == 1) begin : g_instret
      assign inc = retire_count;
    end else begin : g_hpm
      // Selector 0 or beyond NUM_EVENTS matches no event line
      logic hit;
      always_comb begin
        hit = 1'b0;
        for (int k = 0; k < NUM_EVENTS; k++)
          if (mhpmevent[s-2] == 8'(k + 1)) hit = hit | hpm_event[k];
      end
      assign inc = RETIRE_W'(hit);
    end

    assign wen_lo = wcommit && wdec.kind == CSR_K_COUNTER && wdec.num == 5'(N) && !wdec.hi;
    assign wen_hi = wcommit && wdec.kind == CSR_K_COUNTER && wdec.num == 5'(N) &&  wdec.hi;

    letc_core_csr_counter64 #(.INC_W(RETIRE_W)) u_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (inc),
      .inhibit (mcountinhibit[N]),
      .wen_lo  (wen_lo),
      .wen_hi  (wen_hi),
      .wdata   (wnew),
      .count   (cnt[s])
    );
  end

endmodule
